load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Sequential load/store unit sitting directly upstream of Data_Memory. It accepts one memory request from the core over a valid/ready handshake and checks alignment and range. It drives Data_Memory's address, write-enable, write-command and write-data inputs, then captures and sign- or zero-extends the read data. The result is returned over a second valid/ready handshake.

Parameters:
MEM_BYTES, 128, size of Data_Memory in bytes; any access touching a byte at or above this is an error.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size/sign)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  response present
resp_ready  in  1  core accepts response
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  misaligned, out-of-range or illegal funct3
mem_read_address  out  32  to Data_Memory read_address
mem_write_address  out  32  to Data_Memory write_address
mem_write_en  out  1  to Data_Memory write_en
mem_write_command  out  2  to Data_Memory write_command: 00 byte, 01 half, 10 word
mem_write_data  out  32  to Data_Memory write_data
mem_read_data  in  32  from Data_Memory read_data (combinational, little-endian from address)

Behaviour:
- Reset: async assert forces IDLE immediately. All outputs go to 0, except req_ready, which goes to 1 once out of reset. mem_write_en drops asynchronously, so a pending store is aborted and no memory write occurs.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/funct3/addr/wdata. If the request is legal, go to ACCESS. If it is an error, go straight to RESP with resp_error=1 and resp_rdata=0; memory is never touched.
- Legal load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store funct3: 000 SB (cmd 00), 001 SH (cmd 01), 010 SW (cmd 10).
- Any other funct3 is an error.
- Misaligned is an error: half-word with addr[0]=1, or word with addr[1:0]!=0.
- Range is an error when addr+size-1 >= MEM_BYTES. Compute in 33 bits so that wrap near 0xFFFFFFFF is flagged.
- ACCESS (exactly one cycle): mem_read_address and mem_write_address = latched addr.
  - Store: mem_write_en=1, mem_write_command per size, mem_write_data = latched wdata. The write takes effect at the edge ending ACCESS.
  - Load: mem_write_en=0. At the edge ending ACCESS, capture mem_read_data.
  - Extension: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend, LW passes through.
  - Next state is RESP.
- Outside ACCESS: mem_write_en=0 and all mem_* addresses/data hold 0.
- RESP: resp_valid=1, with resp_rdata/resp_error stable until resp_valid&&resp_ready. Then return to IDLE.
- If resp_ready is already high on the first RESP cycle, the handshake completes that cycle.
- req_ready=0 in ACCESS and RESP. There is no same-cycle back-to-back, so the minimum spacing between request acceptances is 3 cycles.
- Latency: request accepted at edge N → mem access cycle N..N+1 → resp_valid from edge N+1 (legal) or asserted after edge N (error).
- req_valid is ignored outside IDLE. Request fields may change freely after acceptance.
- Store responses: resp_rdata=0, resp_error=0.
- Reset asserted during RESP discards the response; resp_valid drops immediately.

Test Plan:
- After reset, with memory bytes 0..3 = AA,81,0F,F0: LW addr 0 → resp_rdata=F00F81AA, resp_error=0, resp_valid 2 cycles after acceptance.
- LB addr 1 → FFFFFF81; LBU addr 1 → 00000081; LH addr 2 → FFFFF00F; LHU addr 2 → 0000F00F.
- SW addr 8 data DEADBEEF, then LW addr 8 → DEADBEEF. Verify mem_write_en high for exactly one cycle with command 10. SB addr 9 data 12, then LW 8 → DEAD12EF.
- SH addr 1, LW addr 2, LW addr 126 (MEM_BYTES=128), funct3 011 → each gives resp_error=1, rdata=0, and mem_write_en never asserts.
- Hold resp_ready=0 for 5 cycles: resp_valid/rdata stable, req_ready=0, and an extra req_valid is not accepted. Release → IDLE next cycle.
- Assert resetn=0 asynchronously mid-ACCESS of SW addr 16: mem_write_en falls immediately, byte 16 is unchanged, outputs are at reset values, and req_ready=1 after deassertion.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, response and Data_Memory-side signals of the load/store unit.
// The unit uses the slave view; the core/memory side uses the master view.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  logic [31:0] mem_read_address;
  logic [31:0] mem_write_address;
  logic        mem_write_en;
  logic [1:0]  mem_write_command;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_read_address, mem_write_address, mem_write_en,
    output mem_write_command, mem_write_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_read_address, mem_write_address, mem_write_en,
    input  mem_write_command, mem_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// Sequential load/store unit in front of Data_Memory: accepts one request,
// checks funct3/alignment/range, performs a one-cycle memory access and
// returns extended load data (or an error) over a valid/ready response.
module load_store_unit #(
  parameter int MEM_BYTES = 128
) (
  input logic              clk,
  input logic              resetn,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic       we_q;
  logic [2:0] funct3_q;

  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_error;
  logic [32:0] last_byte;

  // Access width in bytes for the low two funct3 bits (0 for the illegal 11).
  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // Sign/zero extension of the little-endian read data for each load type.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Request legality; the end address is formed in 33 bits so a wrap past
  // 0xFFFFFFFF still counts as out of range.
  always_comb begin
    funct3_ok    = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    last_byte    = {1'b0, bus.req_addr} + {30'h0, size_of(bus.req_funct3[1:0])} - 33'd1;
    out_of_range = last_byte >= 33'(MEM_BYTES);
    req_error    = !funct3_ok || misaligned || out_of_range;
  end

  // Control FSM with registered outputs; reset also clears the memory-side
  // drive so an in-flight store is abandoned without writing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state                 <= IDLE;
      we_q                  <= 1'b0;
      funct3_q              <= 3'b000;
      bus.req_ready         <= 1'b0;
      bus.resp_valid        <= 1'b0;
      bus.resp_rdata        <= 32'h0;
      bus.resp_error        <= 1'b0;
      bus.mem_read_address  <= 32'h0;
      bus.mem_write_address <= 32'h0;
      bus.mem_write_en      <= 1'b0;
      bus.mem_write_command <= 2'b00;
      bus.mem_write_data    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            we_q          <= bus.req_we;
            funct3_q      <= bus.req_funct3;
            if (req_error) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_error <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end else begin
              state                 <= ACCESS;
              bus.mem_read_address  <= bus.req_addr;
              bus.mem_write_address <= bus.req_addr;
              bus.mem_write_en      <= bus.req_we;
              bus.mem_write_command <= bus.req_we ? bus.req_funct3[1:0] : 2'b00;
              bus.mem_write_data    <= bus.req_we ? bus.req_wdata : 32'h0;
            end
          end
        end
        ACCESS: begin
          state                 <= RESP;
          bus.resp_valid        <= 1'b1;
          bus.resp_error        <= 1'b0;
          bus.resp_rdata        <= we_q ? 32'h0 : extend(funct3_q, bus.mem_read_data);
          bus.mem_read_address  <= 32'h0;
          bus.mem_write_address <= 32'h0;
          bus.mem_write_en      <= 1'b0;
          bus.mem_write_command <= 2'b00;
          bus.mem_write_data    <= 32'h0;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
